// File: rtl/instr_fetch_unit.sv
// Fetch front end: holds the PC, talks req/ack to imem and feeds
// decode from a 2-entry in-order buffer; redirects flush and refetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  typedef enum logic {FETCH, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  count;
  logic        wp;
  logic        rp;
  entry_t      buf_q [0:1];
  entry_t      head;
  logic        req_c;
  logic        push;
  logic        pop;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  always_comb begin
    state_nxt = FETCH;
    req_c     = 1'b0;
    unique case (1'b1)
      (state == FETCH): req_c = (int'(count) < DEPTH);
      (state == FLUSH): req_c = 1'b0;
      default:          req_c = 1'b0;
    endcase
    if (redirect) state_nxt = FLUSH;
  end

  assign imem_req  = req_c & ~rst;
  assign imem_addr = fetch_pc;

  // Redirect beats any same-cycle ack.
  assign push = imem_req & imem_ack & ~redirect;
  assign pop  = out_valid & out_ready;

  assign head      = buf_q[rp];
  assign out_valid = (count != 2'd0) & ~rst;
  assign instr     = out_valid ? head.word : 32'h0;
  assign pc        = out_valid ? head.pc : 32'h0;
  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      wp       <= 1'b0;
      rp       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        count    <= 2'd0;
        wp       <= 1'b0;
        rp       <= 1'b0;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (push) begin
          buf_q[wp] <= '{pc: fetch_pc, word: imem_rdata};
          wp        <= ~wp;
          fetch_pc  <= fetch_pc + 32'd4;
        end
        if (pop) rp <= ~rp;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Random + directed bench for instr_fetch_unit against a queue model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .pc(pc), .op(op),
    .funct3(funct3), .funct7(funct7)
  );

  always #5 clk = ~clk;

  // Model: buffered {pc, word} pairs, next fetch address, flush flag.
  logic [63:0] q[$];
  logic [31:0] mpc;
  bit          mflush;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h00C5_8533;
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic e_req();
    return !rst && !mflush && q.size() < 2;
  endfunction

  function automatic logic e_valid();
    return !rst && q.size() > 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] ei;
    logic [31:0] ep;
    ei = e_valid() ? q[0][31:0] : 32'h0;
    ep = e_valid() ? q[0][63:32] : 32'h0;
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req()});
    if (e_req()) chk("imem_addr", imem_addr, mpc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid()});
    chk("instr", instr, ei);
    chk("pc", pc, ep);
    chk("op", {25'b0, op}, {25'b0, ei[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, ei[14:12]});
    chk("funct7", {25'b0, funct7}, {25'b0, ei[31:25]});
  endtask

  task automatic step();
    bit pu;
    bit po;
    if (rst) begin
      q.delete();
      mpc    = RPC;
      mflush = 0;
    end else if (redirect) begin
      q.delete();
      mpc    = {redirect_pc[31:2], 2'b00};
      mflush = 1;
    end else begin
      pu = e_req() && imem_ack;
      po = e_valid() && out_ready;
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back({mpc, mem(mpc)});
        mpc = mpc + 32'd4;
      end
      mflush = 0;
    end
  endtask

  // Called at a negedge: drive, compare, clock, update model.
  task automatic tick(input logic r, input logic a, input logic rd,
                      input logic re, input logic [31:0] rp);
    rst         = r;
    imem_ack    = a;
    out_ready   = rd;
    redirect    = re;
    redirect_pc = rp;
    imem_rdata  = a ? mem(imem_addr) : $urandom;
    #1;
    compare();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  initial begin
    q.delete();
    mpc    = RPC;
    mflush = 0;
    rst = 1; imem_ack = 0; out_ready = 0; redirect = 0;
    redirect_pc = 0; imem_rdata = 0;
    @(negedge clk);
    tick(1, 1, 1, 0, 0);
    tick(1, 1, 1, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);

    tick(0, 1, 1, 0, 0);
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_pc", pc, 32'h100);
    chk("first_instr", instr, 32'h00C5_8533);
    chk("first_op", {25'b0, op}, 32'h33);
    chk("first_f3", {29'b0, funct3}, 32'h0);
    chk("first_f7", {25'b0, funct7}, 32'h0);
    chk("addr_104", imem_addr, 32'h104);
    tick(0, 1, 1, 0, 0);
    chk("second_pc", pc, 32'h104);
    chk("addr_108", imem_addr, 32'h108);

    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_addr", imem_addr, 32'h108);
    chk("full_head", pc, 32'h100);
    tick(0, 0, 1, 0, 0);
    chk("drain_head", pc, 32'h104);
    tick(0, 0, 1, 0, 0);
    chk("drain_empty", {31'b0, out_valid}, 32'd0);
    chk("resume_addr", imem_addr, 32'h108);

    tick(0, 1, 0, 0, 0);
    tick(0, 1, 1, 0, 0);
    chk("pushpop_head", pc, 32'h10C);
    chk("pushpop_valid", {31'b0, out_valid}, 32'd1);

    tick(0, 1, 0, 1, 32'h2003);
    chk("redir_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd0);
    tick(0, 1, 0, 0, 0);
    chk("redir_addr", imem_addr, 32'h2000);
    chk("redir_req2", {31'b0, imem_req}, 32'd1);
    tick(0, 1, 0, 0, 0);
    chk("redir_pc", pc, 32'h2000);
    chk("redir_next", imem_addr, 32'h2004);

    tick(0, 0, 0, 1, 32'hFFFF_FFFC);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    tick(0, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk("rst2_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_req", {31'b0, imem_req}, 32'd0);
    tick(0, 0, 0, 0, 0);
    chk("rst2_addr", imem_addr, RPC);
    chk("rst2_empty", {31'b0, out_valid}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                       : $urandom;
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 15) == 0,
           rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
